// File: rtl/riscv_defines.sv
// Shared encodings and request bundle for the DIFT load/store unit.
// Data-type codes match the EX-stage data_type field.
package riscv_defines;

    typedef enum logic [1:0] {
        TYPE_WORD = 2'b00,
        TYPE_HALF = 2'b01,
        TYPE_BYTE = 2'b10
    } data_type_e;

    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        WAIT_GNT    = 2'b01,
        WAIT_RVALID = 2'b10
    } lsu_state_e;

    typedef struct packed {
        logic [1:0] dtype;
        logic       sign_ext;
        logic [1:0] offset;
        logic       we;
        logic       rs1_tag;
        logic       prop_en;
    } lsu_req_t;

    function automatic logic [3:0] byte_enable(
        input logic [1:0] dtype,
        input logic [1:0] off
    );
        logic [3:0] be;
        unique case (dtype)
            TYPE_HALF: be = 4'b0011 << {off[1], 1'b0};
            TYPE_BYTE: be = 4'b0001 << off;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic is_misaligned(
        input logic [1:0] dtype,
        input logic [1:0] off
    );
        logic mis;
        unique case (dtype)
            TYPE_WORD: mis = (off != 2'b00);
            TYPE_HALF: mis = off[0];
            default:   mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/riscv_load_align.sv
// Load data alignment: shift the returned word down to the accessed
// byte lane, then zero- or sign-extend byte/half results.
module riscv_load_align
    import riscv_defines::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  dtype,
    input  logic        sign_ext,
    output logic [31:0] data
);

    logic [31:0] shifted;
    logic        sbit;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        sbit    = 1'b0;
        data    = shifted;
        unique case (dtype)
            TYPE_BYTE: begin
                sbit = sign_ext & shifted[7];
                data = {{24{sbit}}, shifted[7:0]};
            end
            TYPE_HALF: begin
                sbit = sign_ext & shifted[15];
                data = {{16{sbit}}, shifted[15:0]};
            end
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/riscv_dift_lsu.sv
// Load/store unit with a one-bit DIFT tag per data word.
// Single outstanding transaction; a new request may issue in the rvalid cycle.
module riscv_dift_lsu
    import riscv_defines::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_req_ex_i,
    input  logic        data_we_ex_i,
    input  logic [1:0]  data_type_ex_i,
    input  logic        data_sign_ext_ex_i,
    input  logic [31:0] data_addr_ex_i,
    input  logic [31:0] data_wdata_ex_i,
    input  logic        data_wdata_tag_ex_i,
    input  logic        data_we_tag_ex_i,
    input  logic        rs1_tag_ex_i,
    input  logic        load_prop_en_ex_i,
    input  logic        ex_valid_i,
    output logic        lsu_ready_ex_o,
    output logic        lsu_ready_wb_o,
    output logic        data_misaligned_o,
    output logic [31:0] data_rdata_wb_o,
    output logic        data_rdata_wb_tag_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    output logic        data_wdata_tag_o,
    output logic        data_we_tag_o,
    input  logic [31:0] data_rdata_i,
    input  logic        data_rdata_tag_i
);

    lsu_state_e  state_q;
    lsu_state_e  state_d;
    lsu_req_t    req_q;
    lsu_req_t    req_d;
    logic [31:0] rdata_wb_q;
    logic        rdata_tag_q;
    logic [31:0] rdata_aligned;
    logic [1:0]  off;
    logic        misaligned;
    logic        can_issue;
    logic        issue;
    logic        wb_en;
    logic        unused_ex_valid;

    assign unused_ex_valid = ex_valid_i;
    assign off             = data_addr_ex_i[1:0];

    assign misaligned = is_misaligned(data_type_ex_i, off);
    assign can_issue  = (state_q == IDLE) ||
                        ((state_q == WAIT_RVALID) && data_rvalid_i);
    assign issue      = can_issue & data_req_ex_i & ~misaligned;

    always_comb begin
        state_d           = state_q;
        data_req_o        = 1'b0;
        data_misaligned_o = 1'b0;
        lsu_ready_wb_o    = 1'b1;
        wb_en             = 1'b0;
        unique case (state_q)
            IDLE: begin
                data_req_o        = issue;
                data_misaligned_o = data_req_ex_i & misaligned;
                if (issue)
                    state_d = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
            end
            WAIT_GNT: begin
                data_req_o = 1'b1;
                if (data_gnt_i)
                    state_d = WAIT_RVALID;
            end
            WAIT_RVALID: begin
                lsu_ready_wb_o = data_rvalid_i;
                if (data_rvalid_i) begin
                    wb_en             = ~req_q.we;
                    data_req_o        = issue;
                    data_misaligned_o = data_req_ex_i & misaligned;
                    if (issue)
                        state_d = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
                    else
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // EX must also hold a new request that arrives before the previous rvalid.
    assign lsu_ready_ex_o = ~((data_req_o & ~data_gnt_i) |
                              ((state_q == WAIT_RVALID) & ~data_rvalid_i &
                               data_req_ex_i));

    assign data_addr_o      = {data_addr_ex_i[31:2], 2'b00};
    assign data_we_o        = data_we_ex_i;
    assign data_be_o        = byte_enable(data_type_ex_i, off);
    assign data_wdata_tag_o = data_wdata_tag_ex_i;
    assign data_we_tag_o    = data_we_o & data_we_tag_ex_i;

    always_comb begin
        unique case (off)
            2'd1:    data_wdata_o = {data_wdata_ex_i[23:0], data_wdata_ex_i[31:24]};
            2'd2:    data_wdata_o = {data_wdata_ex_i[15:0], data_wdata_ex_i[31:16]};
            2'd3:    data_wdata_o = {data_wdata_ex_i[7:0],  data_wdata_ex_i[31:8]};
            default: data_wdata_o = data_wdata_ex_i;
        endcase
    end

    always_comb begin
        req_d          = req_q;
        req_d.dtype    = data_type_ex_i;
        req_d.sign_ext = data_sign_ext_ex_i;
        req_d.offset   = off;
        req_d.we       = data_we_ex_i;
        req_d.rs1_tag  = rs1_tag_ex_i;
        req_d.prop_en  = load_prop_en_ex_i;
    end

    riscv_load_align u_load_align (
        .rdata    (data_rdata_i),
        .offset   (req_q.offset),
        .dtype    (req_q.dtype),
        .sign_ext (req_q.sign_ext),
        .data     (rdata_aligned)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_q       <= '0;
            rdata_wb_q  <= '0;
            rdata_tag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (data_req_o && data_gnt_i)
                req_q <= req_d;
            if (wb_en) begin
                rdata_wb_q  <= rdata_aligned;
                rdata_tag_q <= data_rdata_tag_i |
                               (req_q.rs1_tag & req_q.prop_en);
            end
        end
    end

    assign data_rdata_wb_o     = rdata_wb_q;
    assign data_rdata_wb_tag_o = rdata_tag_q;

endmodule
